// File: rtl/pushbutton_pkg.sv
// Shared definitions for the pushbutton PIO event sequencer.
// Holds the PIO register offsets and the sequencer FSM state encoding.
package pushbutton_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    INIT,
    WAIT_IRQ,
    RD,
    CAPT,
    CLR,
    EMIT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational picker over a pending-request vector.
// Ports:
//   pending - request bits, one per button
//   rr_ptr  - round-robin start index (ignored in fixed-priority mode)
//   grant   - index of the selected request (0 when nothing is pending)
//   any     - at least one request is pending
// ROUND_ROBIN=1 picks the first set bit at or above rr_ptr, wrapping;
// ROUND_ROBIN=0 picks the lowest set bit.
module rr_arbiter #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned CODE_W      = 2
) (
  input  logic [N_BTN-1:0]  pending,
  input  logic [CODE_W-1:0] rr_ptr,
  output logic [CODE_W-1:0] grant,
  output logic              any
);

  always_comb begin
    logic              found;
    logic [CODE_W-1:0] idx;
    int unsigned       start;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    any   = |pending;
    start = (ROUND_ROBIN != 0) ? 32'(rr_ptr) : 32'd0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = CODE_W'((start + k) % N_BTN);
      if (!found && pending[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pushbutton_event_sequencer.sv
// Autonomous Avalon-MM master servicing a pushbutton PIO slave.
// Writes the PIO irq mask, waits for irq, reads and write-1-clears the edge
// capture register, then emits one event per captured button on a
// valid/ready stream.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   enable                - allow new batches (current batch always finishes)
//   mask_cfg              - desired PIO irq mask
//   pio_*                 - Avalon-MM master to the PIO (1-cycle accesses)
//   pio_irq               - PIO interrupt
//   evt_valid/ready/button- event stream
//   busy                  - FSM not idling in WAIT_IRQ
module pushbutton_event_sequencer
  import pushbutton_pkg::*;
#(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned CODE_W      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_BTN-1:0]  mask_cfg,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [31:0]       pio_writedata,
  input  logic [31:0]       pio_readdata,
  input  logic              pio_irq,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_button,
  output logic              busy
);

  state_t             state;
  logic [N_BTN-1:0]   pending;
  logic [N_BTN-1:0]   mask_shadow;
  logic [CODE_W-1:0]  rr_ptr;

  logic [N_BTN-1:0]   capt;
  logic [N_BTN-1:0]   arb_pend;
  logic [CODE_W-1:0]  arb_ptr;
  logic [CODE_W-1:0]  grant;
  logic               arb_any;
  logic               unused_bits;

  assign capt        = pio_readdata[N_BTN-1:0] & mask_shadow;
  assign unused_bits = ^pio_readdata[31:N_BTN];

  // The arbiter looks at the post-acceptance view during EMIT so the next
  // grant can be registered in the same cycle the current one is accepted.
  always_comb begin
    arb_pend = pending;
    arb_ptr  = rr_ptr;
    if (state == EMIT && evt_ready) begin
      arb_pend = pending & ~(N_BTN'(1) << evt_button);
      arb_ptr  = (evt_button == CODE_W'(N_BTN - 1)) ? '0 : evt_button + 1'b1;
    end
  end

  rr_arbiter #(
    .N_BTN      (N_BTN),
    .ROUND_ROBIN(ROUND_ROBIN),
    .CODE_W     (CODE_W)
  ) u_arb (
    .pending(arb_pend),
    .rr_ptr (arb_ptr),
    .grant  (grant),
    .any    (arb_any)
  );

  // Bus strobes are registered on the transition that issues the access, so
  // the read is on the bus during RD and readdata is valid during CAPT. The
  // mask write is registered while in INIT and appears on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      pending        <= '0;
      mask_shadow    <= '0;
      rr_ptr         <= '0;
      pio_address    <= ADDR_DATA;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      evt_valid      <= 1'b0;
      evt_button     <= '0;
      busy           <= 1'b1;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      case (state)
        INIT: begin
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
          pio_address    <= ADDR_MASK;
          pio_writedata  <= 32'(mask_cfg);
          mask_shadow    <= mask_cfg;
          state          <= WAIT_IRQ;
          busy           <= 1'b0;
        end
        WAIT_IRQ: begin
          if (mask_cfg != mask_shadow) begin
            state <= INIT;
            busy  <= 1'b1;
          end else if (enable && pio_irq) begin
            pio_chipselect <= 1'b1;
            pio_address    <= ADDR_EDGE;
            state          <= RD;
            busy           <= 1'b1;
          end
        end
        RD: state <= CAPT;
        CAPT: begin
          pending <= capt;
          if (capt == '0) begin
            state <= WAIT_IRQ;
            busy  <= 1'b0;
          end else begin
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_address    <= ADDR_EDGE;
            pio_writedata  <= 32'(capt);
            state          <= CLR;
          end
        end
        CLR: begin
          evt_valid  <= 1'b1;
          evt_button <= grant;
          state      <= EMIT;
        end
        EMIT: begin
          if (evt_ready) begin
            pending <= arb_pend;
            rr_ptr  <= arb_ptr;
            if (!arb_any) begin
              evt_valid <= 1'b0;
              state     <= WAIT_IRQ;
              busy      <= 1'b0;
            end else begin
              evt_button <= grant;
            end
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
